pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter stage: fetch address with increment, jump and call/return via a LIFO return stack.
// Latency: one cycle. pc, depth and flags are registered with no combinational path from the inputs.
// Backpressure: stall holds pc, stack and depth, and suppresses flag setting for that cycle.
module pc_sequencer #(
  parameter int                 WIDTH      = 8,
  parameter int                 DEPTH      = 4,
  parameter logic [WIDTH-1:0]   RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       jump,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           target,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic             push_en;
  logic [WIDTH-1:0] pc_inc;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;

  // pc+1 wraps naturally at 2^WIDTH; it is both the sequential next address and the return address.
  assign pc_inc   = pc_q + WIDTH'(1);
  assign top_idx  = AW'(depth_q - DW'(1));
  assign push_idx = depth_q[AW-1:0];

  // Next-state selection in priority order: stall > ret > call > jump > increment.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push_en = 1'b0;
    if (stall) begin
      // hold everything, flags included
    end else if (ret) begin
      if (depth_q != '0) begin
        pc_d    = stack_q[top_idx];
        depth_d = depth_q - DW'(1);
      end else begin
        udf_d = 1'b1;
      end
    end else if (call) begin
      if (depth_q != FULL) begin
        push_en = 1'b1;
        depth_d = depth_q + DW'(1);
        pc_d    = target;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (jump) begin
      pc_d = target;
    end else begin
      pc_d = pc_inc;
    end
  end

  // Control state register; reset wins over any requested action.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_ADDR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Return-address storage; contents are meaningless once depth drops, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc        = pc_q;
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of input/expected records plus hand-written wrap/reset sequences.
// Expected values are queued when a vector is driven and compared one cycle later.
// A second instance with RESET_ADDR=8'h10 shares the inputs and is checked where flagged.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset, stall, jump, call, ret;
  logic [7:0] target;
  logic [7:0] pc, pc2;
  logic [2:0] depth, depth2;
  logic       ovf, udf, ovf2, udf2;

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(8), .DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .call(call), .ret(ret),
    .target(target), .pc(pc), .depth(depth), .overflow(ovf), .underflow(udf)
  );

  pc_sequencer #(.WIDTH(8), .DEPTH(4), .RESET_ADDR(8'h10)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .call(call), .ret(ret),
    .target(target), .pc(pc2), .depth(depth2), .overflow(ovf2), .underflow(udf2)
  );

  typedef struct {
    logic       rst, stl, jmp, cal, rt;
    logic [7:0] tgt;
    logic [7:0] e_pc;
    logic [2:0] e_dep;
    logic       e_ovf, e_udf;
    logic       chk2;
    logic [7:0] e_pc2;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   step  = 0;

  function automatic vec_t mk(bit rst, bit stl, bit jmp, bit cal, bit rt, logic [7:0] tgt,
                              logic [7:0] e_pc, int dep, bit o, bit u,
                              bit c2 = 1'b0, logic [7:0] p2 = 8'h00);
    vec_t v;
    v.rst = rst; v.stl = stl; v.jmp = jmp; v.cal = cal; v.rt = rt; v.tgt = tgt;
    v.e_pc = e_pc; v.e_dep = 3'(dep); v.e_ovf = o; v.e_udf = u;
    v.chk2 = c2; v.e_pc2 = p2;
    return v;
  endfunction

  task automatic check_out();
    vec_t e;
    step++;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL step %0d: scoreboard empty, no expected record for DUT output", step);
      return;
    end
    e = sb.pop_front();
    if (pc !== e.e_pc || depth !== e.e_dep || ovf !== e.e_ovf || udf !== e.e_udf) begin
      fails++;
      $display("FAIL step %0d: got pc=%h depth=%0d ovf=%b udf=%b, want pc=%h depth=%0d ovf=%b udf=%b",
               step, pc, depth, ovf, udf, e.e_pc, e.e_dep, e.e_ovf, e.e_udf);
    end
    if (e.chk2) begin
      tests++;
      if (pc2 !== e.e_pc2) begin
        fails++;
        $display("FAIL step %0d reset_addr_10: got pc=%h, want pc=%h", step, pc2, e.e_pc2);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset  = v.rst;
    stall  = v.stl;
    jump   = v.jmp;
    call   = v.cal;
    ret    = v.rt;
    target = v.tgt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; target = 8'h00;

    // reset then idle: 0,1,2,3 and 10,11,12,13 on the second instance
    tbl.push_back(mk(1,0,0,0,0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h10));
    tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h01, 0, 0, 0, 1, 8'h11));
    tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h02, 0, 0, 0, 1, 8'h12));
    tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h03, 0, 0, 0, 1, 8'h13));
    // single call / return from 0x05
    tbl.push_back(mk(0,0,1,0,0, 8'h05, 8'h05, 0, 0, 0));
    tbl.push_back(mk(0,0,0,1,0, 8'h40, 8'h40, 1, 0, 0));
    tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h41, 1, 0, 0));
    tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h42, 1, 0, 0));
    tbl.push_back(mk(0,0,0,0,1, 8'h00, 8'h06, 0, 0, 0));
    // four nested calls, fifth overflows, unwind
    tbl.push_back(mk(0,0,1,0,0, 8'h01, 8'h01, 0, 0, 0));
    tbl.push_back(mk(0,0,0,1,0, 8'h20, 8'h20, 1, 0, 0));
    tbl.push_back(mk(0,0,1,0,0, 8'h21, 8'h21, 1, 0, 0));
    tbl.push_back(mk(0,0,0,1,0, 8'h30, 8'h30, 2, 0, 0));
    tbl.push_back(mk(0,0,1,0,0, 8'h31, 8'h31, 2, 0, 0));
    tbl.push_back(mk(0,0,0,1,0, 8'h40, 8'h40, 3, 0, 0));
    tbl.push_back(mk(0,0,1,0,0, 8'h41, 8'h41, 3, 0, 0));
    tbl.push_back(mk(0,0,0,1,0, 8'h50, 8'h50, 4, 0, 0));
    tbl.push_back(mk(0,0,0,1,0, 8'h60, 8'h50, 4, 1, 0));
    tbl.push_back(mk(0,0,0,0,1, 8'h00, 8'h42, 3, 1, 0));
    tbl.push_back(mk(0,0,0,0,1, 8'h00, 8'h32, 2, 1, 0));
    tbl.push_back(mk(0,0,0,0,1, 8'h00, 8'h22, 1, 1, 0));
    tbl.push_back(mk(0,0,0,0,1, 8'h00, 8'h02, 0, 1, 0));
    // underflow is sticky until reset
    tbl.push_back(mk(0,0,1,0,0, 8'h07, 8'h07, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,1, 8'h00, 8'h07, 0, 1, 1));
    tbl.push_back(mk(0,0,0,0,0, 8'h00, 8'h08, 0, 1, 1));
    tbl.push_back(mk(1,0,0,0,0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h10));
    // stall blocks flag setting even with ret at depth 0
    tbl.push_back(mk(0,1,0,1,1, 8'h55, 8'h00, 0, 0, 0, 1, 8'h10));
    // priority: stall > ret > call > jump
    tbl.push_back(mk(0,0,1,0,0, 8'h02, 8'h02, 0, 0, 0));
    tbl.push_back(mk(0,0,0,1,0, 8'h10, 8'h10, 1, 0, 0));
    tbl.push_back(mk(0,1,1,1,1, 8'h77, 8'h10, 1, 0, 0));
    tbl.push_back(mk(0,0,1,1,1, 8'h77, 8'h03, 0, 0, 0));
    tbl.push_back(mk(0,0,1,1,0, 8'h80, 8'h80, 1, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // wrap FE -> FF -> 00 without flags
    apply(mk(1,0,0,0,0, 8'h00, 8'h00, 0, 0, 0));
    apply(mk(0,0,1,0,0, 8'hFE, 8'hFE, 0, 0, 0));
    apply(mk(0,0,0,0,0, 8'h00, 8'hFF, 0, 0, 0));
    apply(mk(0,0,0,0,0, 8'h00, 8'h00, 0, 0, 0));
    // call at FF pushes 00; the return proves the stack top
    apply(mk(0,0,1,0,0, 8'hFF, 8'hFF, 0, 0, 0));
    apply(mk(0,0,0,1,0, 8'h30, 8'h30, 1, 0, 0));
    apply(mk(0,0,0,0,1, 8'h00, 8'h00, 0, 0, 0));
    // reset together with a call discards the call
    apply(mk(0,0,0,1,0, 8'h30, 8'h30, 1, 0, 0));
    apply(mk(1,0,0,1,0, 8'h60, 8'h00, 0, 0, 0, 1, 8'h10));
    apply(mk(0,0,0,0,0, 8'h00, 8'h01, 0, 0, 0, 1, 8'h11));

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d records left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
